// File: rtl/n64_vbus_tx.sv
// N64 VI multiplexed video bus transmitter: queues parallel {sync,R,G,B} pixels
// and replays each one as the native 4-phase VCLK/nVDSYNC/VD sequence.
module n64_vbus_tx #(
    parameter int COLOR_W    = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               VCLK,
    input  logic               nRST,
    input  logic               en,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [3:0]         pix_sync,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               nVDSYNC,
    output logic [COLOR_W-1:0] VD_o,
    output logic               busy,
    output logic [15:0]        underflow_cnt
);

    localparam int PIX_W = 4 + 3 * COLOR_W;
    localparam int RGB_W = 3 * COLOR_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S    = 3'd1,
        ST_R    = 3'd2,
        ST_G    = 3'd3,
        ST_B    = 3'd4
    } state_t;

    state_t             state_r, state_next_s;
    logic [PIX_W-1:0]   mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r, count_next_s;
    logic [RGB_W-1:0]   cur_rgb_r;
    logic [3:0]         last_sync_r;
    logic               ready_r;
    logic               nvdsync_r, nvdsync_s;
    logic [COLOR_W-1:0] vd_r, vd_s;
    logic               busy_r;
    logic [15:0]        uf_cnt_r;

    logic               push_s, pop_s, empty_s, enter_s_s, underflow_s;
    logic [PIX_W-1:0]   head_s, load_pix_s;

    assign empty_s     = (count_r == CNT_ZERO);
    assign push_s      = pix_valid & ready_r;
    assign head_s      = mem_r[rd_ptr_r];
    assign enter_s_s   = (state_next_s == ST_S);
    assign pop_s       = enter_s_s & ~empty_s;
    assign underflow_s = enter_s_s & empty_s;
    // An empty FIFO at the S boundary replays the last sync code with black colour.
    assign load_pix_s  = pop_s ? head_s : {last_sync_r, {RGB_W{1'b0}}};

    // FIFO storage, no reset needed: occupancy gates every read.
    always_ff @(posedge VCLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {pix_sync, pix_r, pix_g, pix_b};
        end
    end

    // Next occupancy from push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers, occupancy and registered ready flag.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // FSM state register.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; a started pixel always runs through B.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = (en && !empty_s) ? ST_S : ST_IDLE;
            ST_S:    state_next_s = ST_R;
            ST_R:    state_next_s = ST_G;
            ST_G:    state_next_s = ST_B;
            ST_B:    state_next_s = en ? ST_S : ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode for the state being entered.
    always_comb begin
        nvdsync_s = 1'b1;
        vd_s      = '0;
        case (state_next_s)
            ST_S: begin
                nvdsync_s = 1'b0;
                vd_s      = {{(COLOR_W-4){1'b0}}, load_pix_s[PIX_W-1:RGB_W]};
            end
            ST_R:    vd_s = cur_rgb_r[RGB_W-1:2*COLOR_W];
            ST_G:    vd_s = cur_rgb_r[2*COLOR_W-1:COLOR_W];
            ST_B:    vd_s = cur_rgb_r[COLOR_W-1:0];
            default: vd_s = '0;
        endcase
    end

    // Registered bus outputs, pixel latch and underflow counter.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            nvdsync_r   <= 1'b1;
            vd_r        <= '0;
            busy_r      <= 1'b0;
            cur_rgb_r   <= '0;
            last_sync_r <= 4'hF;
            uf_cnt_r    <= 16'h0000;
        end else begin
            nvdsync_r <= nvdsync_s;
            vd_r      <= vd_s;
            busy_r    <= (state_next_s != ST_IDLE);
            if (enter_s_s) begin
                cur_rgb_r   <= load_pix_s[RGB_W-1:0];
                last_sync_r <= load_pix_s[PIX_W-1:RGB_W];
            end else begin
                cur_rgb_r   <= cur_rgb_r;
                last_sync_r <= last_sync_r;
            end
            if (underflow_s && (uf_cnt_r != 16'hFFFF)) begin
                uf_cnt_r <= uf_cnt_r + 16'h0001;
            end else begin
                uf_cnt_r <= uf_cnt_r;
            end
        end
    end

    assign pix_ready     = ready_r;
    assign nVDSYNC       = nvdsync_r;
    assign VD_o          = vd_r;
    assign busy          = busy_r;
    assign underflow_cnt = uf_cnt_r;

endmodule

// File: tb/tb_n64_vbus_tx.sv
// Self-checking bench for n64_vbus_tx: pixel-queue reference model checked every
// cycle, directed literal checks for the key scenarios, then random traffic.
module tb_n64_vbus_tx;

    localparam int CW    = 7;
    localparam int DEPTH = 4;
    localparam int PW    = 4 + 3 * CW;

    logic          VCLK = 1'b0;
    logic          nRST;
    logic          en;
    logic          pix_valid;
    logic          pix_ready;
    logic [3:0]    pix_sync;
    logic [CW-1:0] pix_r, pix_g, pix_b;
    logic          nVDSYNC;
    logic [CW-1:0] VD_o;
    logic          busy;
    logic [15:0]   underflow_cnt;

    int tests = 0;
    int fails = 0;

    n64_vbus_tx #(.COLOR_W(CW), .FIFO_DEPTH(DEPTH)) dut (
        .VCLK(VCLK), .nRST(nRST), .en(en),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sync(pix_sync), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .nVDSYNC(nVDSYNC), .VD_o(VD_o), .busy(busy), .underflow_cnt(underflow_cnt)
    );

    always #5 VCLK = ~VCLK;

    // Reference model: a pixel queue plus "which of the four words is on the bus".
    logic [PW-1:0] m_q[$];
    logic [PW-1:0] m_cur  = '0;
    int            m_ph   = -1;   // -1 = bus idle, 0..3 = sync/R/G/B word
    logic [3:0]    m_last = 4'hF;
    int            m_uf   = 0;
    bit            m_rdy  = 1'b0;

    always @(posedge VCLK or negedge nRST) begin
        int occ;
        bit push;
        if (!nRST) begin
            m_q.delete();
            m_cur = '0; m_ph = -1; m_last = 4'hF; m_uf = 0; m_rdy = 1'b0;
        end else begin
            occ  = m_q.size();
            push = pix_valid && m_rdy;
            if (m_ph == -1) begin
                if (en && occ > 0) begin
                    m_cur = m_q.pop_front();
                    m_ph  = 0;
                end
            end else if (m_ph < 3) begin
                m_ph = m_ph + 1;
            end else if (en) begin
                m_ph = 0;
                if (occ > 0) begin
                    m_cur = m_q.pop_front();
                end else begin
                    m_cur = {m_last, {(3*CW){1'b0}}};
                    if (m_uf < 65535) m_uf = m_uf + 1;
                end
            end else begin
                m_ph = -1;
            end
            if (m_ph == 0) m_last = m_cur[PW-1:3*CW];
            if (push) m_q.push_back({pix_sync, pix_r, pix_g, pix_b});
            m_rdy = (m_q.size() < DEPTH);
        end
    end

    function automatic logic [CW-1:0] model_vd();
        case (m_ph)
            0:       return CW'(m_cur[PW-1:3*CW]);
            1:       return m_cur[3*CW-1:2*CW];
            2:       return m_cur[2*CW-1:CW];
            3:       return m_cur[CW-1:0];
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus nVDSYNC cadence during a busy run.
    int  cyc = 0;
    int  last_low = 0;
    bit  low_seen = 1'b0;
    always @(negedge VCLK) begin
        cyc++;
        chk("model_nvdsync", int'(nVDSYNC), int'(m_ph != 0));
        chk("model_vd", int'(VD_o), int'(model_vd()));
        chk("model_busy", int'(busy), int'(m_ph >= 0));
        chk("model_ready", int'(pix_ready), int'(m_rdy));
        chk("model_underflow", int'(underflow_cnt), m_uf);
        if (!busy || !nRST) begin
            low_seen = 1'b0;
        end else if (nVDSYNC == 1'b0) begin
            if (low_seen) chk("sync_period", cyc - last_low, 4);
            last_low = cyc;
            low_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge VCLK);
        @(negedge VCLK);
    endtask

    task automatic drive_pix(input logic [3:0] s, input logic [CW-1:0] r,
                             input logic [CW-1:0] g, input logic [CW-1:0] b);
        pix_valid = 1'b1; pix_sync = s; pix_r = r; pix_g = g; pix_b = b;
    endtask

    initial begin
        int acc;
        nRST = 1'b0; en = 1'b0;
        drive_pix(4'h5, 7'h55, 7'h2A, 7'h7F);

        // Reset held with valid asserted.
        repeat (3) tick();
        chk("rst_nvdsync", int'(nVDSYNC), 1);
        chk("rst_vd", int'(VD_o), 0);
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_underflow", int'(underflow_cnt), 0);
        nRST = 1'b1; pix_valid = 1'b0;
        tick();
        chk("rst_release_ready", int'(pix_ready), 1);

        // Single pixel, en dropped while G is on the bus.
        en = 1'b1;
        drive_pix(4'hB, 7'h11, 7'h22, 7'h33);
        tick();
        pix_valid = 1'b0;
        chk("single_t0_busy", int'(busy), 0);
        tick();
        chk("single_s_nv", int'(nVDSYNC), 0);
        chk("single_s_vd", int'(VD_o), 'h0B);
        tick();
        chk("single_r_vd", int'(VD_o), 'h11);
        chk("single_r_nv", int'(nVDSYNC), 1);
        tick();
        chk("single_g_vd", int'(VD_o), 'h22);
        en = 1'b0;
        tick();
        chk("single_b_vd", int'(VD_o), 'h33);
        tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_vd", int'(VD_o), 0);
        chk("idle_nv", int'(nVDSYNC), 1);

        // Underflow filler repeats the last sync code.
        en = 1'b1;
        drive_pix(4'h7, 7'h01, 7'h02, 7'h03);
        tick();
        pix_valid = 1'b0;
        repeat (4) tick();
        tick();
        chk("uf_s_vd", int'(VD_o), 'h07);
        chk("uf_s_nv", int'(nVDSYNC), 0);
        chk("uf_cnt1", int'(underflow_cnt), 1);
        tick();
        chk("uf_r_vd", int'(VD_o), 0);
        repeat (3) tick();
        chk("uf_cnt2", int'(underflow_cnt), 2);
        en = 1'b0;
        repeat (4) tick();
        chk("uf_idle_busy", int'(busy), 0);

        // Backpressure: fill with en low, then release and push the rest.
        acc = 0;
        for (int i = 0; i < 10 && pix_ready; i++) begin
            drive_pix(4'(i), 7'($urandom), 7'($urandom), 7'($urandom));
            tick();
            acc++;
        end
        pix_valid = 1'b0;
        chk("bp_accepts", acc, DEPTH);
        chk("bp_ready_low", int'(pix_ready), 0);
        en = 1'b1;
        for (int i = 0; i < 40 && acc < 6; i++) begin
            drive_pix(4'(8 + acc), 7'($urandom), 7'($urandom), 7'($urandom));
            if (pix_ready) acc++;
            tick();
        end
        pix_valid = 1'b0;
        chk("bp_total", acc, 6);
        for (int i = 0; i < 100 && m_q.size() != 0; i++) tick();
        en = 1'b0;
        for (int i = 0; i < 10 && busy; i++) tick();
        chk("bp_drain_idle", int'(busy), 0);

        // Async reset while R is on the bus with a pixel still queued.
        drive_pix(4'h3, 7'h44, 7'h45, 7'h46);
        tick();
        drive_pix(4'h9, 7'h12, 7'h13, 7'h14);
        tick();
        pix_valid = 1'b0;
        en = 1'b1;
        tick();
        tick();
        chk("pre_rst_r_vd", int'(VD_o), 'h44);
        #2 nRST = 1'b0;
        #1;
        chk("async_nv", int'(nVDSYNC), 1);
        chk("async_vd", int'(VD_o), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_ready", int'(pix_ready), 0);
        @(negedge VCLK);
        tick();
        nRST = 1'b1;
        repeat (6) begin
            tick();
            chk("post_rst_no_stale", int'(busy), 0);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            pix_valid = ($urandom_range(0, 99) < 40);
            pix_sync  = 4'($urandom);
            pix_r     = 7'($urandom);
            pix_g     = 7'($urandom);
            pix_b     = 7'($urandom);
            en        = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 999) == 0) nRST = 1'b0;
            else nRST = 1'b1;
            tick();
        end
        nRST = 1'b1;
        pix_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
